plab4_net_domain_merge: RTL and testbench
=========================================

// Module: plab4_net_domain_merge
//
// PURPOSE
// - Transmit-side counterpart of plab4_net_demux on each inter-router ring link.
// - Takes the two per-domain channels leaving a router (d1 = domain 0, d2 = domain 1).
// - Buffers each channel in its own queue.
// - Merges them onto the single link (val/rdy, control msg, data msg, domain tag) that the far-end demux splits again.
// - Round-robin arbitration: neither domain can starve the other.
//
// PARAMETERS
// - p_msg_cnbits   41  width of control message, VC_NET_MSG_NBITS(32,3,3)
// - p_msg_dnbits   32  width of data message
// - p_num_entries  2   depth of each per-domain queue (>=2, power of two)
//
// PORTS
// - clk                 in   1   clock
// - reset               in   1   asynchronous, active-high reset
// - in_val_d1           in   1   domain-0 message valid
// - in_rdy_d1           out  1   domain-0 queue can accept
// - in_msg_control_d1   in   cn  domain-0 control message
// - in_msg_data_d1      in   dn  domain-0 data message
// - in_val_d2           in   1   domain-1 message valid
// - in_rdy_d2           out  1   domain-1 queue can accept
// - in_msg_control_d2   in   cn  domain-1 control message
// - in_msg_data_d2      in   dn  domain-1 data message
// - out_val             out  1   link message valid
// - out_rdy             in   1   link/demux ready
// - out_msg_control     out  cn  link control message
// - out_msg_data        out  dn  link data message
// - out_domain          out  1   0 = from d1, 1 = from d2; steers the far-end demux
//
// BEHAVIOUR
// - Reset (async, any cycle):
//   - Both queues empty, pri = 0, lock = 0.
//   - Outputs: out_val = 0, in_rdy_d1 = in_rdy_d2 = 1, out_domain = 0, out_msg_* = 0.
//   - Messages in flight at reset are dropped.
// - Enqueue: on in_val_dX & in_rdy_dX at a rising edge. Control and data are stored together in one entry.
// - in_rdy_dX = !full_X. No pipelined-full: a full queue deasserts rdy even if it dequeues that same cycle.
// - Latency: no bypass. A message enqueued at edge t can appear on out_* no earlier than the cycle after t.
// - Grant selection:
//   - lock = 1: grant = locked domain.
//   - lock = 0, both nonempty: grant = pri.
//   - lock = 0, one nonempty: grant = that domain.
//   - lock = 0, none nonempty: out_val = 0.
// - Outputs: out_val = !empty_grant. out_domain and out_msg_* come from the head of the granted queue. out_msg_* = 0 when out_val = 0.
// - Stability: out_val & !out_rdy sets lock and holds the grant. out_domain and out_msg_* stay stable until the fire.
// - Fire (out_val & out_rdy): dequeue the granted head, pri <= ~grant, lock <= 0.
// - Simultaneous enq and deq on the same non-full queue: both happen, count unchanged.
// - Wrap-around: read/write pointers are log2(p_num_entries) bits and wrap naturally. Full/empty use a count register of log2(p_num_entries)+1 bits.
// - Fairness: under continuous traffic on both domains, fires alternate d1, d2, d1, ...
//
// STRUCTURE
// - Shared header plab4-net-domain.v holds:
//   - localparams DOMAIN_D1 = 1'b0 and DOMAIN_D2 = 1'b1.
//   - The VC_NET_MSG_NBITS width macro, reused from vc-net-msgs.
// - Sub-module plab4_net_domain_queue (count/pointer FIFO of {control, data}, depth p_num_entries) is instantiated twice: q_d1 and q_d2.
// - Arbiter state (pri, lock, locked domain) and output muxing live in this module.
// - Module is dropped into RingNetAlt-Sep between each router out0/out2 pair and the peer demux.
//
// TESTING
// 1. Reset mid-stream: fill q_d1 with 2 msgs, assert reset for 1 cycle -> out_val = 0, in_rdy_d1 = 1, queues empty, pri = 0.
// 2. Single domain: send ctrl 0x1..0x4 on d1 with out_rdy = 1 -> out emits 0x1..0x4 in order, out_domain = 0, first out_val one cycle after first enq.
// 3. Alternation: d1 sends 0xA0..0xA3, d2 sends 0xB0..0xB3, out_rdy = 1 -> sequence A0 B0 A1 B1 A2 B2 A3 B3, out_domain 0 1 0 1 ...
// 4. Backpressure hold: d1 head 0x11, d2 head 0x22, pri = 1, out_rdy = 0 for 5 cycles -> out holds 0x22/domain 1 every cycle; no change when d1 enqueues more.
// 5. Full: out_rdy = 0, push 3 on d2 -> third push sees in_rdy_d2 = 0. Raise out_rdy -> in_rdy_d2 = 1 the cycle after the first fire.
// 6. Data integrity: random val/rdy on all ports for 10k cycles with a scoreboard per domain -> no loss, reorder or duplication; out_msg_data matches its control.

Source files
------------

// File: rtl/plab4_net_domain_merge_pkg.sv
// Shared domain encodings and network message width helper for the
// domain merge/demux pair on the RingNetAlt-Sep links.
package plab4_net_domain_merge_pkg;

  localparam logic DOMAIN_D1 = 1'b0;
  localparam logic DOMAIN_D2 = 1'b1;

  // Control message = payload + opaque + src + dest fields.
  function automatic int vc_net_msg_nbits(input int p_payload, input int p_opaque,
                                          input int p_srcdest);
    return p_payload + p_opaque + 2 * p_srcdest;
  endfunction

endpackage

// File: rtl/plab4_net_domain_queue.sv
// Count/pointer FIFO holding one {control, data} entry per slot. No bypass and
// no pipelined-full: rdy reflects only the registered count.
module plab4_net_domain_queue
  import plab4_net_domain_merge_pkg::*;
#(
  parameter int p_nbits       = 73,
  parameter int p_num_entries = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  input  logic               deq_en,
  output logic               deq_val,
  output logic [p_nbits-1:0] deq_msg
);

  localparam int PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [p_nbits-1:0] mem_q [p_num_entries];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full, empty, enq, deq;

  assign full    = (count_q == CNT_W'(p_num_entries));
  assign empty   = (count_q == '0);
  assign enq     = enq_val & ~full;
  assign deq     = deq_en & ~empty;
  assign enq_rdy = ~full;
  assign deq_val = ~empty;
  assign deq_msg = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (enq && !deq)      count_d = count_q + CNT_W'(1);
    else if (deq && !enq) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; stale entries are unreachable once the count clears.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_msg;
  end

endmodule

// File: rtl/plab4_net_domain_merge.sv
// Merges the two per-domain router output channels onto one ring link with a
// domain tag, using round-robin arbitration that locks the grant while stalled.
module plab4_net_domain_merge
  import plab4_net_domain_merge_pkg::*;
#(
  parameter int p_msg_cnbits  = vc_net_msg_nbits(32, 3, 3),
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_entries = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_val_d1,
  output logic                    in_rdy_d1,
  input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
  input  logic [p_msg_dnbits-1:0] in_msg_data_d1,
  input  logic                    in_val_d2,
  output logic                    in_rdy_d2,
  input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
  input  logic [p_msg_dnbits-1:0] in_msg_data_d2,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [p_msg_cnbits-1:0] out_msg_control,
  output logic [p_msg_dnbits-1:0] out_msg_data,
  output logic                    out_domain
);

  localparam int MSG_W = p_msg_cnbits + p_msg_dnbits;

  logic             val_d1, val_d2, deq_d1, deq_d2;
  logic [MSG_W-1:0] head_d1, head_d2, head;
  logic             grant, fire;
  logic             pri_q, pri_d;
  logic             lock_q, lock_d;
  logic             lock_dom_q, lock_dom_d;

  plab4_net_domain_queue #(.p_nbits(MSG_W), .p_num_entries(p_num_entries)) q_d1 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (in_val_d1),
    .enq_rdy (in_rdy_d1),
    .enq_msg ({in_msg_control_d1, in_msg_data_d1}),
    .deq_en  (deq_d1),
    .deq_val (val_d1),
    .deq_msg (head_d1)
  );

  plab4_net_domain_queue #(.p_nbits(MSG_W), .p_num_entries(p_num_entries)) q_d2 (
    .clk     (clk),
    .reset   (reset),
    .enq_val (in_val_d2),
    .enq_rdy (in_rdy_d2),
    .enq_msg ({in_msg_control_d2, in_msg_data_d2}),
    .deq_en  (deq_d2),
    .deq_val (val_d2),
    .deq_msg (head_d2)
  );

  // A stalled grant stays locked so the far-end demux sees a stable message.
  always_comb begin
    grant = pri_q;
    if (lock_q)                grant = lock_dom_q;
    else if (val_d1 && val_d2) grant = pri_q;
    else if (val_d1)           grant = DOMAIN_D1;
    else if (val_d2)           grant = DOMAIN_D2;
  end

  assign out_val         = (grant == DOMAIN_D2) ? val_d2 : val_d1;
  assign head            = (grant == DOMAIN_D2) ? head_d2 : head_d1;
  assign out_msg_control = out_val ? head[MSG_W-1 -: p_msg_cnbits] : '0;
  assign out_msg_data    = out_val ? head[p_msg_dnbits-1:0] : '0;
  assign out_domain      = out_val ? grant : DOMAIN_D1;
  assign fire            = out_val & out_rdy;
  assign deq_d1          = fire & (grant == DOMAIN_D1);
  assign deq_d2          = fire & (grant == DOMAIN_D2);

  always_comb begin
    pri_d      = pri_q;
    lock_d     = lock_q;
    lock_dom_d = lock_dom_q;
    if (fire) begin
      pri_d  = ~grant;
      lock_d = 1'b0;
    end else if (out_val) begin
      lock_d     = 1'b1;
      lock_dom_d = grant;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_q      <= DOMAIN_D1;
      lock_q     <= 1'b0;
      lock_dom_q <= DOMAIN_D1;
    end else begin
      pri_q      <= pri_d;
      lock_q     <= lock_d;
      lock_dom_q <= lock_dom_d;
    end
  end

endmodule

// File: tb/tb_plab4_net_domain_merge.sv
// Scoreboard bench for plab4_net_domain_merge: per-domain expected queues plus
// an abstract round-robin/hold model checked by a negedge monitor.
module tb_plab4_net_domain_merge;

  localparam int CN = 41;
  localparam int DN = 32;
  localparam int NE = 2;

  typedef struct packed {
    logic [CN-1:0] c;
    logic [DN-1:0] d;
  } msg_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_val_d1 = 1'b0, in_val_d2 = 1'b0;
  logic          in_rdy_d1, in_rdy_d2;
  logic [CN-1:0] in_msg_control_d1 = '0, in_msg_control_d2 = '0;
  logic [DN-1:0] in_msg_data_d1 = '0, in_msg_data_d2 = '0;
  logic          out_val, out_domain;
  logic          out_rdy = 1'b0;
  logic [CN-1:0] out_msg_control;
  logic [DN-1:0] out_msg_data;

  plab4_net_domain_merge #(.p_msg_cnbits(CN), .p_msg_dnbits(DN), .p_num_entries(NE)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_val_d1         (in_val_d1),
    .in_rdy_d1         (in_rdy_d1),
    .in_msg_control_d1 (in_msg_control_d1),
    .in_msg_data_d1    (in_msg_data_d1),
    .in_val_d2         (in_val_d2),
    .in_rdy_d2         (in_rdy_d2),
    .in_msg_control_d2 (in_msg_control_d2),
    .in_msg_data_d2    (in_msg_data_d2),
    .out_val           (out_val),
    .out_rdy           (out_rdy),
    .out_msg_control   (out_msg_control),
    .out_msg_data      (out_msg_data),
    .out_domain        (out_domain)
  );

  always #5 clk = ~clk;

  msg_t q1[$], q2[$];
  int   checks = 0;
  int   failures = 0;
  logic acc1, acc2;

  // Abstract link model: last winner, and whether a stalled offer is pending.
  logic pri_m = 1'b0, stalled = 1'b0, stall_dom = 1'b0;
  logic n1, n2, edom;
  msg_t h;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_out_val", 64'(out_val), 64'd0);
      chk("rst_in_rdy_d1", 64'(in_rdy_d1), 64'd1);
      chk("rst_in_rdy_d2", 64'(in_rdy_d2), 64'd1);
      chk("rst_out_domain", 64'(out_domain), 64'd0);
      chk("rst_out_ctrl", 64'(out_msg_control), 64'd0);
      chk("rst_out_data", 64'(out_msg_data), 64'd0);
      pri_m   = 1'b0;
      stalled = 1'b0;
    end else begin
      n1 = (q1.size() != 0);
      n2 = (q2.size() != 0);
      chk("in_rdy_d1", 64'(in_rdy_d1), 64'(q1.size() < NE));
      chk("in_rdy_d2", 64'(in_rdy_d2), 64'(q2.size() < NE));
      chk("out_val", 64'(out_val), 64'(n1 | n2));
      if (n1 || n2) begin
        if (stalled)       edom = stall_dom;
        else if (n1 && n2) edom = pri_m;
        else               edom = n1 ? 1'b0 : 1'b1;
        h = edom ? q2[0] : q1[0];
        chk("out_domain", 64'(out_domain), 64'(edom));
        chk("out_ctrl", 64'(out_msg_control), 64'(h.c));
        chk("out_data", 64'(out_msg_data), 64'(h.d));
        if (out_rdy) begin
          if (edom) void'(q2.pop_front());
          else      void'(q1.pop_front());
          pri_m   = ~edom;
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          stall_dom = edom;
        end
      end else begin
        chk("idle_ctrl", 64'(out_msg_control), 64'd0);
        chk("idle_data", 64'(out_msg_data), 64'd0);
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; acceptance is recorded just before the next one.
  task automatic tick();
    #8;
    acc1 = in_val_d1 && in_rdy_d1 && !reset;
    acc2 = in_val_d2 && in_rdy_d2 && !reset;
    if (acc1) q1.push_back('{c: in_msg_control_d1, d: in_msg_data_d1});
    if (acc2) q2.push_back('{c: in_msg_control_d2, d: in_msg_data_d2});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v1, input logic [CN-1:0] c1, input logic v2,
                       input logic [CN-1:0] c2, input logic ordy);
    in_val_d1 = v1; in_msg_control_d1 = c1; in_msg_data_d1 = ~c1[DN-1:0] ^ 32'h5a5a_0000;
    in_val_d2 = v2; in_msg_control_d2 = c2; in_msg_data_d2 = ~c2[DN-1:0] ^ 32'h0000_a5a5;
    out_rdy   = ordy;
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (8) tick();
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    q1.delete();
    q2.delete();
    #1;
    chk("reset_async_out_val", 64'(out_val), 64'd0);
    chk("reset_async_rdy_d1", 64'(in_rdy_d1), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [CN-1:0] rnd_ctrl();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[CN-1:0];
  endfunction

  initial begin
    int i1, i2, guard;
    logic [CN-1:0] a[4];
    logic [CN-1:0] b[4];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-stream with two messages queued on d1
    drive(1'b1, CN'(41'h7), 1'b0, '0, 1'b0); tick();
    drive(1'b1, CN'(41'h8), 1'b0, '0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t1_full_before_reset", 64'(in_rdy_d1), 64'd0);
    do_reset();
    tick();
    chk("t1_empty_after_reset", 64'(out_val), 64'd0);

    // Single domain, in order, one-cycle latency
    chk("t2_empty_before", 64'(out_val), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      guard = 0;
      do begin
        drive(1'b1, CN'(i), 1'b0, '0, 1'b1);
        tick();
        guard++;
      end while (!acc1 && guard < 20);
      chk("t2_accept", 64'(acc1), 64'd1);
      if (i == 1) begin
        chk("t2_latency_val", 64'(out_val), 64'd1);
        chk("t2_latency_ctrl", 64'(out_msg_control), 64'h1);
      end
    end
    drain();

    // Alternation between domains
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a[i] = CN'(41'hA0 + i);
      b[i] = CN'(41'hB0 + i);
    end
    i1 = 0; i2 = 0; guard = 0;
    while ((i1 < 4 || i2 < 4) && guard < 60) begin
      drive(i1 < 4, (i1 < 4) ? a[i1] : '0, i2 < 4, (i2 < 4) ? b[i2] : '0, 1'b1);
      tick();
      if (acc1) i1++;
      if (acc2) i2++;
      guard++;
    end
    chk("t3_all_sent", 64'(i1 + i2), 64'd8);
    drain();

    // Backpressure hold with pri pointing at d2
    do_reset();
    drive(1'b1, CN'(41'h10), 1'b0, '0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, '0, 1'b1); tick();
    drive(1'b1, CN'(41'h11), 1'b1, CN'(41'h22), 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      drive(k == 1, CN'(41'h12), 1'b0, '0, 1'b0);
      chk("t4_hold_ctrl", 64'(out_msg_control), 64'h22);
      chk("t4_hold_dom", 64'(out_domain), 64'd1);
      tick();
    end
    drain();

    // Full queue on d2
    drive(1'b1, CN'(41'h31), 1'b0, '0, 1'b0); tick();
    drive(1'b1, CN'(41'h31), 1'b0, '0, 1'b0); tick();
    drive(1'b0, '0, 1'b1, CN'(41'h41), 1'b0); tick();
    drive(1'b0, '0, 1'b1, CN'(41'h42), 1'b0); tick();
    drive(1'b0, '0, 1'b1, CN'(41'h43), 1'b0);
    chk("t5_rdy_full", 64'(in_rdy_d2), 64'd0);
    tick();
    chk("t5_third_rejected", 64'(acc2), 64'd0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    guard = 0;
    while (!in_rdy_d2 && guard < 10) begin
      tick();
      guard++;
    end
    chk("t5_rdy_recovers", 64'(in_rdy_d2), 64'd1);
    drain();

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)), rnd_ctrl(), 1'($urandom_range(0, 1)), rnd_ctrl(),
            $urandom_range(0, 3) != 0);
      in_msg_data_d1 = $urandom;
      in_msg_data_d2 = $urandom;
      tick();
    end
    drain();
    chk("t6_q1_drained", 64'(q1.size()), 64'd0);
    chk("t6_q2_drained", 64'(q2.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
